// File: rtl/demux2_buf_pkg.sv
// demux2_buf shared types and constants.
// Channel selector enum, counter width and counter increment helper.
package demux2_pkg;

   typedef enum logic {
      CH0 = 1'b0,
      CH1 = 1'b1
   } ch_e;

   localparam int CNT_W = 8;

   // Modulo-256 increment; the natural wrap of the vector is intended.
   function automatic logic [CNT_W-1:0] cnt_inc(
      input logic [CNT_W-1:0] c
   );
      return c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/demux2_buf_fifo.sv
// fifo_sync: single-clock FIFO with registered storage and an
// async active-low reset. Ports: clk, reset_n, push, wdata, pop,
// head (word at read pointer), full, empty.
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // No full-bypass: a push into a full FIFO is dropped even if a
   // pop happens in the same cycle; the caller never offers one.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Head is read straight from storage; storage is cleared on
   // reset so the head reads zero while the FIFO is reset.
   assign head = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux2_buf.sv
// demux2_buf: buffered 1:2 valid/ready stream demultiplexer.
// in_* stream is steered by in_sel into per-channel FIFOs that drive
// out0_* / out1_*; count0/count1 tally accepted words (mod 256).
module demux2_buf
   import demux2_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] count0,
   output logic [CNT_W-1:0] count1
);

   ch_e  sel;
   logic full0;
   logic full1;
   logic empty0;
   logic empty1;
   logic accept;
   logic push0;
   logic push1;
   logic pop0;
   logic pop1;

   assign sel = ch_e'(in_sel);

   // Ready depends only on the addressed channel, not on in_valid.
   always_comb begin
      in_ready = 1'b0;
      unique case (sel)
         CH0: in_ready = !full0;
         CH1: in_ready = !full1;
      endcase
   end

   assign accept = in_valid && in_ready;
   assign push0  = accept && (sel == CH0);
   assign push1  = accept && (sel == CH1);

   assign out0_valid = !empty0;
   assign out1_valid = !empty1;
   assign pop0       = out0_valid && out0_ready;
   assign pop1       = out1_valid && out1_ready;

   fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo0 (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push0),
      .wdata   (in_data),
      .pop     (pop0),
      .head    (out0_data),
      .full    (full0),
      .empty   (empty0)
   );

   fifo_sync #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo1 (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push1),
      .wdata   (in_data),
      .pop     (pop1),
      .head    (out1_data),
      .full    (full1),
      .empty   (empty1)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count0 <= '0;
         count1 <= '0;
      end else begin
         if (push0) begin
            count0 <= cnt_inc(count0);
         end
         if (push1) begin
            count1 <= cnt_inc(count1);
         end
      end
   end

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_demux2_buf;

   localparam int WIDTH = 8;
   localparam int DEPTH = 2;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [WIDTH-1:0] in_data;
   logic             in_sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [WIDTH-1:0] out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [7:0]       count0;
   logic [7:0]       count1;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: one queue per channel plus counters.
   logic [WIDTH-1:0] q0[$];
   logic [WIDTH-1:0] q1[$];
   int               m_cnt0 = 0;
   int               m_cnt1 = 0;
   bit               last_acc = 1'b0;

   demux2_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .count0     (count0),
      .count1     (count1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic bit m_ready();
      if (in_sel) return q1.size() < DEPTH;
      return q0.size() < DEPTH;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         m_cnt0 = 0;
         m_cnt1 = 0;
         last_acc = 1'b0;
      end else begin
         bit acc;
         bit p0;
         bit p1;
         acc = in_valid && m_ready();
         p0  = (q0.size() > 0) && out0_ready;
         p1  = (q1.size() > 0) && out1_ready;
         if (p0) void'(q0.pop_front());
         if (p1) void'(q1.pop_front());
         if (acc && !in_sel) begin
            q0.push_back(in_data);
            m_cnt0 = (m_cnt0 + 1) % 256;
         end
         if (acc && in_sel) begin
            q1.push_back(in_data);
            m_cnt1 = (m_cnt1 + 1) % 256;
         end
         last_acc = acc;
      end
   end

   always @(negedge clk) begin
      chk("out0_valid", 32'(out0_valid), 32'(q0.size() != 0));
      chk("out1_valid", 32'(out1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
      if (q1.size() != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
      chk("in_ready", 32'(in_ready), 32'(m_ready()));
      chk("count0", 32'(count0), 32'(m_cnt0));
      chk("count1", 32'(count1), 32'(m_cnt1));
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input bit s,
                        input logic [WIDTH-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      in_data    = '0;
      in_sel     = 1'b0;
      in_valid   = 1'b0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      step();
      step();
      chk("rst_out0_valid", 32'(out0_valid), 32'd0);
      chk("rst_out1_valid", 32'(out1_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out0_data", 32'(out0_data), 32'd0);
      chk("rst_out1_data", 32'(out1_data), 32'd0);
      chk("rst_counts", {16'd0, count1, count0}, 32'd0);
      reset_n = 1'b1;
      step();

      // Alternating routing, both consumers ready.
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      drive(1'b1, 1'b0, 8'h11);
      step();
      chk("alt_o0_v", 32'(out0_valid), 32'd1);
      chk("alt_o0_11", 32'(out0_data), 32'h11);
      drive(1'b1, 1'b1, 8'h22);
      step();
      chk("alt_o1_22", 32'(out1_data), 32'h22);
      chk("alt_o0_drained", 32'(out0_valid), 32'd0);
      drive(1'b1, 1'b0, 8'h33);
      step();
      chk("alt_o0_33", 32'(out0_data), 32'h33);
      chk("alt_o1_drained", 32'(out1_valid), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      step();
      chk("alt_count0", 32'(count0), 32'd2);
      chk("alt_count1", 32'(count1), 32'd1);

      // Fill ch0, then route around it to ch1.
      out0_ready = 1'b0;
      drive(1'b1, 1'b0, 8'hA0);
      step();
      drive(1'b1, 1'b0, 8'hA1);
      step();
      drive(1'b1, 1'b0, 8'hA2);
      chk("fill_ready_lo", 32'(in_ready), 32'd0);
      drive(1'b1, 1'b1, 8'hB0);
      chk("fill_ready_sw", 32'(in_ready), 32'd1);
      step();
      chk("fill_o1_B0", 32'(out1_data), 32'hB0);
      chk("fill_o0_A0", 32'(out0_data), 32'hA0);

      // Full plus pop: push refused that cycle, taken the next.
      drive(1'b1, 1'b0, 8'hA2);
      out0_ready = 1'b1;
      #1;
      chk("fullpop_ready", 32'(in_ready), 32'd0);
      step();
      chk("fullpop_A1", 32'(out0_data), 32'hA1);
      chk("fullpop_ready1", 32'(in_ready), 32'd1);
      step();
      chk("fullpop_A2", 32'(out0_data), 32'hA2);
      drive(1'b0, 1'b0, 8'h00);
      step();
      chk("fullpop_empty", 32'(out0_valid), 32'd0);

      // Steady push/pop at occupancy 1.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 8'(8'h40 + i));
         step();
         chk("occ1_valid", 32'(out0_valid), 32'd1);
         chk("occ1_data", 32'(out0_data), 32'(8'h40 + i));
      end
      drive(1'b0, 1'b0, 8'h00);
      step();

      // Random readies and traffic, model checks every cycle.
      for (int i = 0; i < 40; i++) begin
         out0_ready = 1'($urandom_range(0, 1));
         out1_ready = 1'($urandom_range(0, 1));
         if (in_valid && !last_acc) begin
            in_sel = 1'($urandom_range(0, 1));
         end else begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom_range(0, 255));
         end
         step();
      end

      // Reset mid-stream with two words buffered.
      drive(1'b0, 1'b0, 8'h00);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      step();
      step();
      drive(1'b1, 1'b0, 8'hC0);
      step();
      drive(1'b1, 1'b1, 8'hC1);
      step();
      drive(1'b0, 1'b0, 8'h00);
      chk("mid_buffered", {30'd0, out1_valid, out0_valid}, 32'd3);
      reset_n = 1'b0;
      #1;
      step();
      chk("mid_o0_v", 32'(out0_valid), 32'd0);
      chk("mid_o1_v", 32'(out1_valid), 32'd0);
      chk("mid_counts", {16'd0, count1, count0}, 32'd0);
      chk("mid_ready", 32'(in_ready), 32'd1);
      reset_n = 1'b1;
      step();

      // 256 words to ch1 wrap count1 back to 0.
      out1_ready = 1'b1;
      for (int i = 0; i < 256; i++) begin
         drive(1'b1, 1'b1, 8'(i));
         step();
         if (i == 254) chk("wrap_255", 32'(count1), 32'd255);
      end
      drive(1'b0, 1'b0, 8'h00);
      step();
      chk("wrap_count1", 32'(count1), 32'd0);
      chk("wrap_count0", 32'(count0), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
